mac_dot_sequencer: RTL and testbench

- Controller that sequences one shared four-lane int8 MAC datapath (4 signed 8x8 lanes plus a 32-bit sum input, combinational) through a dot product of arbitrary element length.
- Accepts a start command with length and bias, then streams packed 4-element words on a valid/ready input.
- Drives the MAC lane-enable count, operands and running sum, and accumulates across beats.
- Returns the 32-bit result on a valid/ready output.
- Sits between the accelerator's operand fetch logic and the MAC datapath instance.

---
 rtl/mac_dot_sequencer.sv | 132 +++++++++++++
 tb/tb_mac_dot_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_sequencer.sv
// ============================================================================
// Module   : mac_dot_sequencer
// Purpose  : Sequences a shared 4-lane int8 MAC through an arbitrary-length
//            dot product. Optional macro MAC_SEQ_RELU_EN clamps negative
//            results to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_dot_sequencer #(
  parameter int LEN_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [ACC_W-1:0] bias,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [2:0]       mac_valid,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic [ACC_W-1:0] mac_sumin,
  input  logic [ACC_W-1:0] mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] c_lanes_max = LEN_W'(4);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_remaining;
  logic [2:0]       w_lanes;
  logic             w_load;
  logic             w_accept;
  logic [ACC_W-1:0] w_result;

  // Lane count for the current beat; remaining is never 0 while in RUN.
  assign w_lanes = (r_remaining >= c_lanes_max) ? 3'd4 : r_remaining[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    res_valid   = 1'b0;
    mac_valid   = 3'd1;
    mac_a       = '0;
    mac_b       = '0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_load      = 1'b1;
          w_state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready  = 1'b1;
        mac_valid = w_lanes;
        mac_a     = in_a;
        mac_b     = in_b;
        if (in_valid && !abort) begin
          w_accept = 1'b1;
          if (LEN_W'(w_lanes) == r_remaining) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Abort clears the element count but deliberately leaves acc untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_remaining <= '0;
    end else if (abort) begin
      r_remaining <= '0;
    end else if (w_load) begin
      r_acc       <= bias;
      r_remaining <= len;
    end else if (w_accept) begin
      r_acc       <= mac_out;
      r_remaining <= r_remaining - LEN_W'(w_lanes);
    end
  end

`ifdef MAC_SEQ_RELU_EN
  assign w_result = r_acc[ACC_W-1] ? '0 : r_acc;
`else
  assign w_result = r_acc;
`endif

  assign busy      = (r_state != S_IDLE);
  assign mac_sumin = r_acc;
  assign res_data  = (r_state == S_DONE) ? w_result : '0;

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_sequencer.sv
// ============================================================================
// Module   : tb_mac_dot_sequencer
// Purpose  : Directed self-checking bench for mac_dot_sequencer with a
//            behavioural 4-lane int8 MAC attached.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_dot_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic [31:0] bias;
  logic        abort;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  mac_valid;
  logic [31:0] mac_a;
  logic [31:0] mac_b;
  logic [31:0] mac_sumin;
  logic [31:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  int total = 0;
  int bad   = 0;

  mac_dot_sequencer #(.LEN_W(16), .ACC_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .bias      (bias),
    .abort     (abort),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_valid (mac_valid),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_sumin (mac_sumin),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MAC datapath model: mac_valid==0 means all four lanes.
  always_comb begin
    int pa;
    int pb;
    mac_out = mac_sumin;
    for (int k = 0; k < 4; k++) begin
      pa = int'($signed(mac_a[8*k +: 8]));
      pb = int'($signed(mac_b[8*k +: 8]));
      if (mac_valid == 3'd0 || k < int'(mac_valid)) begin
        mac_out = mac_out + 32'(pa * pb);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".in_ready"},  32'(in_ready),  32'd0);
    chk({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, ".res_data"},  res_data,       32'd0);
    chk({tag, ".mac_valid"}, 32'(mac_valid), 32'd1);
    chk({tag, ".mac_a"},     mac_a,          32'd0);
    chk({tag, ".mac_b"},     mac_b,          32'd0);
    chk({tag, ".mac_sumin"}, mac_sumin,      32'd0);
  endtask

  initial begin
    logic [31:0] exp_neg1;
    logic [31:0] exp_neg2;
`ifdef MAC_SEQ_RELU_EN
    exp_neg1 = 32'd0;
    exp_neg2 = 32'd0;
`else
    exp_neg1 = 32'hFFFFFF9D;
    exp_neg2 = 32'hFFFFFFFE;
`endif
    rst_n = 1'b0; start = 1'b0; len = '0; bias = '0; abort = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;

    step(); #1;
    chk_reset_values("rst");
    step(); rst_n = 1'b1;

    // Full words: len=8, bias=5 -> 5 + 10 + 10 = 25
    step(); start = 1'b1; len = 16'd8; bias = 32'd5; #1;
    chk("t1.idle_in_ready", 32'(in_ready), 32'd0);
    step(); start = 1'b0; in_valid = 1'b1; in_a = 32'h01020304; in_b = 32'h01010101; #1;
    chk("t1.busy", 32'(busy), 32'd1);
    chk("t1.in_ready", 32'(in_ready), 32'd1);
    chk("t1.mac_valid0", 32'(mac_valid), 32'd4);
    chk("t1.sumin0", mac_sumin, 32'd5);
    chk("t1.mac_a", mac_a, 32'h01020304);
    step(); #1;
    chk("t1.mac_valid1", 32'(mac_valid), 32'd4);
    chk("t1.sumin1", mac_sumin, 32'd15);
    step(); in_valid = 1'b0; #1;
    chk("t1.res_valid", 32'(res_valid), 32'd1);
    chk("t1.res_data", res_data, 32'd25);
    chk("t1.done_in_ready", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    step(); res_ready = 1'b0; #1;
    chk("t1.res_valid_drop", 32'(res_valid), 32'd0);
    chk("t1.idle_busy", 32'(busy), 32'd0);

    // Partial final word: len=6 -> 8 + 14 = 22
    step(); start = 1'b1; len = 16'd6; bias = 32'd0;
    step(); start = 1'b0; in_valid = 1'b1; in_a = 32'h01010101; in_b = 32'h02020202; #1;
    chk("t2.mac_valid0", 32'(mac_valid), 32'd4);
    step(); in_a = 32'h0A0B0304; in_b = 32'h01010202; #1;
    chk("t2.mac_valid1", 32'(mac_valid), 32'd2);
    chk("t2.sumin1", mac_sumin, 32'd8);
    step(); in_valid = 1'b0; #1;
    chk("t2.res_valid", 32'(res_valid), 32'd1);
    chk("t2.res_data", res_data, 32'd22);
    res_ready = 1'b1;
    step(); res_ready = 1'b0;

    // Zero length: result is the bias, no operand beats
    step(); start = 1'b1; len = 16'd0; bias = 32'h12345678;
    step(); start = 1'b0; #1;
    chk("t3.in_ready", 32'(in_ready), 32'd0);
    chk("t3.res_valid", 32'(res_valid), 32'd1);
    chk("t3.res_data", res_data, 32'h12345678);
    res_ready = 1'b1;
    step(); res_ready = 1'b0; #1;
    chk("t3.idle", 32'(busy), 32'd0);

    // Bubbles and result backpressure: len=8, bias=1, each beat adds 4
    step(); start = 1'b1; len = 16'd8; bias = 32'd1;
    step(); start = 1'b0; in_valid = 1'b0; in_a = 32'h01010101; in_b = 32'h01010101;
    step(); #1;
    chk("t4.bubble0", mac_sumin, 32'd1);
    in_valid = 1'b1;
    step(); in_valid = 1'b0; #1;
    chk("t4.beat0", mac_sumin, 32'd5);
    step(); #1;
    chk("t4.bubble1", mac_sumin, 32'd5);
    chk("t4.bubble1_busy", 32'(res_valid), 32'd0);
    in_valid = 1'b1;
    step(); in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4.stall_valid", 32'(res_valid), 32'd1);
      chk("t4.stall_data", res_data, 32'd9);
      step();
    end
    res_ready = 1'b1;
    step(); res_ready = 1'b0; #1;
    chk("t4.idle", 32'(busy), 32'd0);

    // Abort after one beat of a len=12 run; acc is kept
    step(); start = 1'b1; len = 16'd12; bias = 32'd0;
    step(); start = 1'b0; in_valid = 1'b1; in_a = 32'h01010101; in_b = 32'h01010101;
    step(); abort = 1'b1;
    step(); abort = 1'b0; in_valid = 1'b0; #1;
    chk("t5.abort_busy", 32'(busy), 32'd0);
    chk("t5.abort_in_ready", 32'(in_ready), 32'd0);
    chk("t5.abort_res_valid", 32'(res_valid), 32'd0);
    chk("t5.abort_acc_kept", mac_sumin, 32'd4);
    start = 1'b1; abort = 1'b1;
    step(); start = 1'b0; abort = 1'b0; #1;
    chk("t5.start_abort_idle", 32'(busy), 32'd0);
    start = 1'b1; len = 16'd4; bias = 32'd0;
    step(); start = 1'b0; #1;
    chk("t5.restart_busy", 32'(busy), 32'd1);
    chk("t5.restart_lanes", 32'(mac_valid), 32'd4);
    chk("t5.restart_sumin", mac_sumin, 32'd0);

    // Asynchronous reset while in RUN
    in_valid = 1'b1; in_a = 32'h05050505; in_b = 32'h03030303;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("arst");
    in_valid = 1'b0;
    step(); rst_n = 1'b1;

    // Signed accumulation, optionally clamped by ReLU
    step(); start = 1'b1; len = 16'd4; bias = 32'hFFFFFF9C;
    step(); start = 1'b0; in_valid = 1'b1; in_a = 32'h00000001; in_b = 32'h00000001;
    step(); in_valid = 1'b0; #1;
    chk("t6.neg_bias", res_data, exp_neg1);
    res_ready = 1'b1;
    step(); res_ready = 1'b0;
    step(); start = 1'b1; len = 16'd4; bias = 32'd0;
    step(); start = 1'b0; in_valid = 1'b1; in_a = 32'h000000FF; in_b = 32'h00000002;
    step(); in_valid = 1'b0; #1;
    chk("t6.neg_product", res_data, exp_neg2);
    res_ready = 1'b1;
    step(); res_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
